// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point exponent path: sequencer
// states, add/subtract op encoding, default bias and accumulator width helper.
package fp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUM  = 2'd1,
    S_BIAS = 2'd2,
    S_NORM = 2'd3
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  localparam int DEFAULT_N    = 32'sd8;
  localparam int DEFAULT_BIAS = 32'sd127;

  // Accumulator width: two guard bits give headroom for a+b and a sign bit.
  function automatic int exp_w(input int n);
    return n + 32'sd2;
  endfunction

endpackage

// File: rtl/exp_addsub.sv
// W-bit add/subtract unit on a parallel-prefix carry-lookahead adder.
// Subtract is an add of the inverted operand with carry-in 1.
module exp_addsub
  import fp_pkg::*;
#(
  parameter int W = 32'sd10
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  addsub_op_e   i_op,
  output logic [W-1:0] o_sum
);

  logic [W-1:0] w_b_eff;
  logic [W-1:0] w_p0;
  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W-1:0] w_g_prev;
  logic [W-1:0] w_p_prev;
  logic         w_cin;

  // Kogge-Stone prefix tree; carry-in is folded into bit 0 generate
  always_comb begin
    w_g_prev = {W{1'b0}};
    w_p_prev = {W{1'b0}};
    w_cin    = (i_op == OP_SUB) ? 1'b1 : 1'b0;
    w_b_eff  = (i_op == OP_SUB) ? ~i_b : i_b;
    w_p0     = i_a ^ w_b_eff;
    w_g      = i_a & w_b_eff;
    w_p      = w_p0;
    w_g[0]   = w_g[0] | (w_p0[0] & w_cin);
    for (int d = 1; d < W; d = d * 2) begin
      w_g_prev = w_g;
      w_p_prev = w_p;
      for (int i = d; i < W; i++) begin
        w_g[i] = w_g_prev[i] | (w_p_prev[i] & w_g_prev[i-d]);
        w_p[i] = w_p_prev[i] & w_p_prev[i-d];
      end
    end
    o_sum = w_p0 ^ {w_g[W-2:0], w_cin};
  end

endmodule

// File: rtl/fp_exp_ctrl.sv
// Exponent sequencer for the FP multiplier: exp_a + exp_b - BIAS + norm_inc
// computed one operation per cycle through a single shared add/subtract unit,
// then saturated with overflow/underflow reporting.
// Optional feature macro: FP_EXP_SPECIAL_EN (all-ones / zero operand
// short-circuit with 2-cycle latency; when undefined `zero` is tied low).
module fp_exp_ctrl
  import fp_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int BIAS = DEFAULT_BIAS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] exp_a,
  input  logic [N-1:0] exp_b,
  input  logic         norm_inc,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] exp_r,
  output logic         ovf,
  output logic         unf,
  output logic         zero
);

  localparam int           W      = exp_w(N);
  localparam logic [W-1:0] BIAS_W = W'(BIAS);
  localparam logic [W-1:0] SAT_W  = W'((32'sd2 ** N) - 32'sd1);
  localparam logic [N-1:0] ONES_N = {N{1'b1}};

  state_e       r_state;
  state_e       w_state_nxt;
  logic [W-1:0] r_acc;
  logic [N-1:0] r_exp_b;
  logic         r_ready;
  logic         r_done;
  logic [N-1:0] r_exp_r;
  logic         r_ovf;
  logic         r_unf;

  logic         w_accept;
  logic         w_special;
  logic [W-1:0] w_operand;
  addsub_op_e   w_op;
  logic [W-1:0] w_sum;

  logic [N-1:0] w_norm_exp;
  logic         w_norm_ovf;
  logic         w_norm_unf;
  logic [N-1:0] w_res_exp;
  logic         w_res_ovf;
  logic         w_res_unf;
  logic         w_res_zero;

`ifdef FP_EXP_SPECIAL_EN
  logic w_any_ones;
  logic w_any_zero;
  logic r_special;
  logic r_spec_ovf;
  logic r_spec_zero;
  logic r_zero;

  assign w_any_ones = (exp_a == ONES_N) || (exp_b == ONES_N);
  assign w_any_zero = (exp_a == {N{1'b0}}) || (exp_b == {N{1'b0}});
  assign w_special  = w_any_ones || w_any_zero;
  assign zero       = r_zero;
`else
  assign w_special  = 1'b0;
  assign zero       = 1'b0;
`endif

  assign ready = r_ready;
  assign done  = r_done;
  assign exp_r = r_exp_r;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

  exp_addsub #(.W(W)) u_addsub (
    .i_a   (r_acc),
    .i_b   (w_operand),
    .i_op  (w_op),
    .o_sum (w_sum)
  );

  // Next-state and shared-adder operand selection
  always_comb begin
    w_state_nxt = r_state;
    w_operand   = {W{1'b0}};
    w_op        = OP_ADD;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_special ? S_NORM : S_SUM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SUM: begin
        w_operand   = {{(W-N){1'b0}}, r_exp_b};
        w_op        = OP_ADD;
        w_state_nxt = S_BIAS;
      end
      S_BIAS: begin
        w_operand   = BIAS_W;
        w_op        = OP_SUB;
        w_state_nxt = S_NORM;
      end
      S_NORM: begin
        w_operand   = {{(W-1){1'b0}}, norm_inc};
        w_op        = OP_ADD;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Saturating resolve of the final accumulator value (signed)
  always_comb begin
    w_norm_exp = {N{1'b0}};
    w_norm_ovf = 1'b0;
    w_norm_unf = 1'b0;
    if ($signed(w_sum) >= $signed(SAT_W)) begin
      w_norm_exp = ONES_N;
      w_norm_ovf = 1'b1;
    end else if ($signed(w_sum) <= $signed({W{1'b0}})) begin
      w_norm_exp = {N{1'b0}};
      w_norm_unf = 1'b1;
    end else begin
      w_norm_exp = w_sum[N-1:0];
    end
  end

  // Pick short-circuit result when a special operand was seen at accept
  always_comb begin
`ifdef FP_EXP_SPECIAL_EN
    w_res_exp  = r_special ? (r_spec_ovf ? ONES_N : {N{1'b0}}) : w_norm_exp;
    w_res_ovf  = r_special ? r_spec_ovf : w_norm_ovf;
    w_res_unf  = r_special ? 1'b0 : w_norm_unf;
    w_res_zero = r_special ? r_spec_zero : 1'b0;
`else
    w_res_exp  = w_norm_exp;
    w_res_ovf  = w_norm_ovf;
    w_res_unf  = w_norm_unf;
    w_res_zero = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, operand latch and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= {W{1'b0}};
      r_exp_b <= {N{1'b0}};
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_exp_r <= {N{1'b0}};
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_ready <= (w_state_nxt == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= {{(W-N){1'b0}}, exp_a};
            r_exp_b <= exp_b;
            r_exp_r <= {N{1'b0}};
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
          end
        end
        S_SUM, S_BIAS: begin
          r_acc <= w_sum;
        end
        S_NORM: begin
          r_acc   <= w_sum;
          r_exp_r <= w_res_exp;
          r_ovf   <= w_res_ovf;
          r_unf   <= w_res_unf;
          r_done  <= 1'b1;
        end
        default: begin
          r_acc <= {W{1'b0}};
        end
      endcase
    end
  end

`ifdef FP_EXP_SPECIAL_EN
  // Short-circuit classification captured at accept, zero flag output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_special   <= 1'b0;
      r_spec_ovf  <= 1'b0;
      r_spec_zero <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_special   <= w_special;
        r_spec_ovf  <= w_any_ones;
        r_spec_zero <= w_any_zero;
        r_zero      <= 1'b0;
      end else if (r_state == S_NORM) begin
        r_zero      <= w_res_zero;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_exp_ctrl.sv
// Directed self-checking bench for fp_exp_ctrl (N=8, BIAS=127).
module tb_fp_exp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic       norm_inc;
  logic       ready;
  logic       done;
  logic [7:0] exp_r;
  logic       ovf;
  logic       unf;
  logic       zero;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ni;
    logic [7:0] e;
    logic       ovf;
    logic       unf;
    logic       zero;
    logic [3:0] lat;
  } vec_t;

  // Expected values hand-computed from a + b - 127 + ni with saturation.
  vec_t vecs [12] = '{
    '{8'd130, 8'd125, 1'b0, 8'd128, 1'b0, 1'b0, 1'b0, 4'd3},
    '{8'd130, 8'd125, 1'b1, 8'd129, 1'b0, 1'b0, 1'b0, 4'd3},
    '{8'd254, 8'd127, 1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 4'd3},
    '{8'd254, 8'd127, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 4'd3},
    '{8'd200, 8'd200, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0, 4'd3},
    '{8'd50,  8'd60,  1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 4'd3},
    '{8'd64,  8'd63,  1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 4'd3},
    '{8'd64,  8'd63,  1'b1, 8'd1,   1'b0, 1'b0, 1'b0, 4'd3},
    '{8'd128, 8'd1,   1'b0, 8'd2,   1'b0, 1'b0, 1'b0, 4'd3},
`ifdef FP_EXP_SPECIAL_EN
    '{8'd0,   8'd150, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 4'd1},
    '{8'd255, 8'd0,   1'b0, 8'd255, 1'b1, 1'b0, 1'b1, 4'd1},
    '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 4'd1}
`else
    '{8'd0,   8'd150, 1'b0, 8'd23,  1'b0, 1'b0, 1'b0, 4'd3},
    '{8'd255, 8'd0,   1'b0, 8'd128, 1'b0, 1'b0, 1'b0, 4'd3},
    '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 4'd3}
`endif
  };

  fp_exp_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .exp_a    (exp_a),
    .exp_b    (exp_b),
    .norm_inc (norm_inc),
    .ready    (ready),
    .done     (done),
    .exp_r    (exp_r),
    .ovf      (ovf),
    .unf      (unf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Present operands for one edge; returns 1 time unit after that edge.
  task automatic do_accept(input logic [7:0] a, input logic [7:0] b, input logic ni);
    exp_a    = a;
    exp_b    = b;
    norm_inc = ni;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  // Count edges until done is seen, bounded to 8 edges.
  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; exp_a = 8'd0; exp_b = 8'd0; norm_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({ready, done, ovf, unf, zero} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got rdy/done/ovf/unf/zero=%b required 10000", {ready, done, ovf, unf, zero});
    end
    n_checks++;
    if (exp_r !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_exp_r: got %0d required 0", exp_r);
    end
  endtask

  task automatic test_exponent_table();
    int lat;
    bit seen;
    for (int i = 0; i < 12; i++) begin
      do_accept(vecs[i].a, vecs[i].b, vecs[i].ni);
      n_checks++;
      if (ready !== 1'b0) begin
        n_errors++;
        $display("FAIL vec%0d_busy_ready: got %b required 0", i, ready);
      end
      wait_done(lat, seen);
      n_checks++;
      if (seen !== 1'b1) begin
        n_errors++;
        $display("FAIL vec%0d_done_timeout: got no done required done", i);
      end
      n_checks++;
      if (lat !== int'(vecs[i].lat)) begin
        n_errors++;
        $display("FAIL vec%0d_latency: got %0d edges required %0d", i, lat, vecs[i].lat);
      end
      n_checks++;
      if (ready !== 1'b1) begin
        n_errors++;
        $display("FAIL vec%0d_done_ready: got %b required 1", i, ready);
      end
      n_checks++;
      if (exp_r !== vecs[i].e) begin
        n_errors++;
        $display("FAIL vec%0d_exp_r: got %0d required %0d", i, exp_r, vecs[i].e);
      end
      n_checks++;
      if ({ovf, unf, zero} !== {vecs[i].ovf, vecs[i].unf, vecs[i].zero}) begin
        n_errors++;
        $display("FAIL vec%0d_flags: got ovf/unf/zero=%b required %b", i, {ovf, unf, zero},
                 {vecs[i].ovf, vecs[i].unf, vecs[i].zero});
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({done, exp_r} !== {1'b0, vecs[i].e}) begin
        n_errors++;
        $display("FAIL vec%0d_hold: got done=%b exp_r=%0d required done=0 exp_r=%0d", i, done, exp_r, vecs[i].e);
      end
    end
  endtask

  task automatic test_ignore_busy_start();
    int extra = 0;
    do_accept(8'd130, 8'd125, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ignore_busy_ready: got %b required 0", ready);
    end
    exp_a = 8'd10; exp_b = 8'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if ({done, exp_r, ovf, unf} !== {1'b1, 8'd128, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL ignore_result: got done=%b exp_r=%0d ovf=%b unf=%b required 1 128 0 0", done, exp_r, ovf, unf);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_errors++;
      $display("FAIL ignore_no_second_done: got %0d done pulses required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    do_accept(8'd130, 8'd125, 1'b1);
    wait_done(lat, seen);
    n_checks++;
    if ({seen, exp_r, ready} !== {1'b1, 8'd129, 1'b1}) begin
      n_errors++;
      $display("FAIL b2b_first: got seen=%b exp_r=%0d ready=%b required 1 129 1", seen, exp_r, ready);
    end
    exp_a = 8'd200; exp_b = 8'd200; norm_inc = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if ({done, ready, exp_r} !== {1'b0, 1'b0, 8'd0}) begin
      n_errors++;
      $display("FAIL b2b_accept_clear: got done=%b ready=%b exp_r=%0d required 0 0 0", done, ready, exp_r);
    end
    wait_done(lat, seen);
    n_checks++;
    if ({seen, lat[3:0], exp_r, ovf, unf} !== {1'b1, 4'd3, 8'd255, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_second: got seen=%b lat=%0d exp_r=%0d ovf=%b unf=%b required 1 3 255 1 0",
               seen, lat, exp_r, ovf, unf);
    end
  endtask

  task automatic test_reset_with_start();
    int extra = 0;
    exp_a = 8'd130; exp_b = 8'd125; rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    n_checks++;
    if ({ready, done, ovf, unf, zero, exp_r} !== {5'b10000, 8'd0}) begin
      n_errors++;
      $display("FAIL rst_start_state: got rdy/done/ovf/unf/zero=%b exp_r=%0d required 10000 0",
               {ready, done, ovf, unf, zero}, exp_r);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_errors++;
      $display("FAIL rst_start_no_done: got %0d done pulses required 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int extra = 0;
    int lat;
    bit seen;
    do_accept(8'd254, 8'd127, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({ready, done, ovf, unf, zero, exp_r} !== {5'b10000, 8'd0}) begin
      n_errors++;
      $display("FAIL rst_mid_state: got rdy/done/ovf/unf/zero=%b exp_r=%0d required 10000 0",
               {ready, done, ovf, unf, zero}, exp_r);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_errors++;
      $display("FAIL rst_mid_no_done: got %0d done pulses required 0", extra);
    end
    do_accept(8'd130, 8'd125, 1'b0);
    wait_done(lat, seen);
    n_checks++;
    if ({seen, lat[3:0], exp_r} !== {1'b1, 4'd3, 8'd128}) begin
      n_errors++;
      $display("FAIL rst_mid_recover: got seen=%b lat=%0d exp_r=%0d required 1 3 128", seen, lat, exp_r);
    end
  endtask

  initial begin
    test_reset();
    test_exponent_table();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_with_start();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached required normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
